bp_update_sched: RTL

//  Buffers resolved-branch outcomes from the execute-stage branch unit and schedules them onto the

---
 rtl/bp_update_sched_if.sv | 48 ++++
 rtl/bp_update_sched.sv | 91 +++++++++
 2 files changed

// File: rtl/bp_update_sched_if.sv
// Predictor-update scheduler bus: resolve input, BHT/BTB update outputs, status.
// Stats outputs exist only when BP_UPD_SCHED_STATS_EN is defined.
interface bp_update_sched_if #(
    parameter int VLEN = 64
);
    logic            flush_i;
    logic            res_valid_i;
    logic [VLEN-1:0] res_pc_i;
    logic [VLEN-1:0] res_target_i;
    logic            res_taken_i;
    logic            res_conditional_i;
    logic            res_to_reg_i;
    logic            bht_valid_o;
    logic [VLEN-1:0] bht_pc_o;
    logic            bht_taken_o;
    logic            bht_ready_i;
    logic            btb_valid_o;
    logic [VLEN-1:0] btb_pc_o;
    logic [VLEN-1:0] btb_target_o;
    logic            btb_ready_i;
    logic            full_o;
    logic            drop_o;
`ifdef BP_UPD_SCHED_STATS_EN
    logic [31:0]     stat_bht_o;
    logic [31:0]     stat_btb_o;
    logic [31:0]     stat_drop_o;
`endif

    modport slave (
        input  flush_i, res_valid_i, res_pc_i, res_target_i, res_taken_i,
               res_conditional_i, res_to_reg_i, bht_ready_i, btb_ready_i,
        output bht_valid_o, bht_pc_o, bht_taken_o, btb_valid_o, btb_pc_o,
               btb_target_o, full_o, drop_o
`ifdef BP_UPD_SCHED_STATS_EN
        , output stat_bht_o, stat_btb_o, stat_drop_o
`endif
    );

    modport master (
        output flush_i, res_valid_i, res_pc_i, res_target_i, res_taken_i,
               res_conditional_i, res_to_reg_i, bht_ready_i, btb_ready_i,
        input  bht_valid_o, bht_pc_o, bht_taken_o, btb_valid_o, btb_pc_o,
               btb_target_o, full_o, drop_o
`ifdef BP_UPD_SCHED_STATS_EN
        , input stat_bht_o, stat_btb_o, stat_drop_o
`endif
    );
endinterface

// File: rtl/bp_update_sched.sv
// In-order FIFO scheduling resolved-branch updates onto BHT/BTB predictor ports.
// BP_UPD_SCHED_STATS_EN adds saturating pop/drop counters (not cleared by flush).
module bp_update_sched #(
    parameter int VLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    bp_update_sched_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic            taken;
        logic            kind;   // 0 = BHT, 1 = BTB
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          new_entry;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            empty, full, enq, pop, accept;

    assign head   = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign enq    = bus.res_valid_i && (bus.res_conditional_i || bus.res_to_reg_i);
    assign pop    = !empty && (head.kind ? bus.btb_ready_i : bus.bht_ready_i);
    // A full queue still takes the new entry when the head leaves in the same cycle.
    assign accept = enq && (!full || pop) && !bus.flush_i;

    assign new_entry = '{pc: bus.res_pc_i, target: bus.res_target_i,
                         taken: bus.res_taken_i, kind: bus.res_to_reg_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.bht_valid_o  = !empty && !head.kind;
    assign bus.btb_valid_o  = !empty &&  head.kind;
    assign bus.bht_pc_o     = head.pc;
    assign bus.bht_taken_o  = head.taken;
    assign bus.btb_pc_o     = head.pc;
    assign bus.btb_target_o = head.target;
    assign bus.full_o       = full;
    assign bus.drop_o       = enq && full && !pop && !bus.flush_i;

`ifdef BP_UPD_SCHED_STATS_EN
    logic [31:0] stat_bht, stat_btb, stat_drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_bht  <= '0;
            stat_btb  <= '0;
            stat_drop <= '0;
        end else begin
            if (pop && !bus.flush_i && !head.kind && stat_bht != '1) stat_bht <= stat_bht + 1'b1;
            if (pop && !bus.flush_i &&  head.kind && stat_btb != '1) stat_btb <= stat_btb + 1'b1;
            if (bus.drop_o && stat_drop != '1)                       stat_drop <= stat_drop + 1'b1;
        end
    end

    assign bus.stat_bht_o  = stat_bht;
    assign bus.stat_btb_o  = stat_btb;
    assign bus.stat_drop_o = stat_drop;
`endif
endmodule
